// File: rtl/arm_pipelined_pkg.sv
// Shared types and constants for the ARM pipelined hazard controller.
// Forward-select encodings, memory handshake FSM states, and the PC register address.
package arm_pipelined_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

  localparam logic [3:0] PC_REG = 4'd15;

endpackage

// File: rtl/arm_pipelined_mem_wait_fsm.sv
// Data-memory wait-state handshake: raises memstall while an access is pending,
// gives up after MaxWait cycles and latches a sticky timeout flag.
module arm_pipelined_mem_wait_fsm
  import arm_pipelined_pkg::*;
#(
  parameter int MaxWait = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic mem_access_i,
  input  logic dmem_ready_i,
  output logic memstall_o,
  output logic mem_timeout_o
);

  localparam int CW = (MaxWait > 2) ? $clog2(MaxWait) : 1;
  localparam logic [CW-1:0] LAST = CW'(MaxWait - 1);

  mem_state_e    state_q;
  logic [CW-1:0] wait_cnt_q;
  logic          timeout_q;
  logic          pending;

  assign pending = mem_access_i & ~dmem_ready_i;

  // The final wait cycle (counter == LAST) releases the pipeline instead of stalling.
  always_comb begin
    memstall_o = 1'b0;
    case (state_q)
      MEM_IDLE: memstall_o = pending;
      MEM_WAIT: memstall_o = pending & (wait_cnt_q != LAST);
      default:  memstall_o = 1'b0;
    endcase
    if (rst_i) memstall_o = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= MEM_IDLE;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        MEM_IDLE: begin
          if (pending) begin
            state_q    <= MEM_WAIT;
            wait_cnt_q <= CW'(1);
          end
        end
        MEM_WAIT: begin
          if (!pending) begin
            state_q    <= MEM_IDLE;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == LAST) begin
            state_q    <= MEM_IDLE;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
          end
        end
        default: begin
          state_q    <= MEM_IDLE;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  assign mem_timeout_o = timeout_q;

endmodule

// File: rtl/arm_pipelined_hazard_controller.sv
// Hazard controller for the 5-stage ARM pipeline: forwarding selects, load-use and
// PC hazard stalls/flushes, data-memory wait stalls and a stall-cycle counter.
module arm_pipelined_hazard_controller
  import arm_pipelined_pkg::*;
#(
  parameter int RegAddrWidth = 4,
  parameter int MaxWait      = 16,
  parameter int CntWidth     = 16
) (
  input  logic                    i_CLK,
  input  logic                    i_RESET,
  input  logic [RegAddrWidth-1:0] i_RA1D,
  input  logic [RegAddrWidth-1:0] i_RA2D,
  input  logic [RegAddrWidth-1:0] i_RA1E,
  input  logic [RegAddrWidth-1:0] i_RA2E,
  input  logic [RegAddrWidth-1:0] i_WA3E,
  input  logic [RegAddrWidth-1:0] i_WA3M,
  input  logic [RegAddrWidth-1:0] i_WA3W,
  input  logic                    i_RegWriteM,
  input  logic                    i_RegWriteW,
  input  logic                    i_MemToRegE,
  input  logic                    i_PCSrcD,
  input  logic                    i_PCSrcE,
  input  logic                    i_PCSrcM,
  input  logic                    i_PCSrcW,
  input  logic                    i_BranchTakenE,
  input  logic                    i_MemAccessM,
  input  logic                    i_DMemReady,
  output logic                    o_DMemReq,
  output logic                    o_StallF,
  output logic                    o_StallD,
  output logic                    o_StallE,
  output logic                    o_StallM,
  output logic                    o_FlushD,
  output logic                    o_FlushE,
  output logic                    o_FlushW,
  output logic [1:0]              o_ForwardAE,
  output logic [1:0]              o_ForwardBE,
  output logic                    o_MemTimeout,
  output logic [CntWidth-1:0]     o_StallCycles
);

  localparam logic [RegAddrWidth-1:0] PC_ADDR = RegAddrWidth'(PC_REG);

  logic                memstall;
  logic                ldrstall;
  logic                pcpend;
  fwd_sel_e            fwd_a;
  fwd_sel_e            fwd_b;
  logic [CntWidth-1:0] stall_cnt_q;
  logic [CntWidth-1:0] stall_cnt_d;

  arm_pipelined_mem_wait_fsm #(
    .MaxWait(MaxWait)
  ) u_mem_wait_fsm (
    .clk_i        (i_CLK),
    .rst_i        (i_RESET),
    .mem_access_i (i_MemAccessM),
    .dmem_ready_i (i_DMemReady),
    .memstall_o   (memstall),
    .mem_timeout_o(o_MemTimeout)
  );

  // The PC is read through its own path and must never take a forwarded value.
  always_comb begin
    fwd_a = FWD_RF;
    if (i_RA1E != PC_ADDR) begin
      if (i_RegWriteM && (i_RA1E == i_WA3M))      fwd_a = FWD_MEM;
      else if (i_RegWriteW && (i_RA1E == i_WA3W)) fwd_a = FWD_WB;
    end
    fwd_b = FWD_RF;
    if (i_RA2E != PC_ADDR) begin
      if (i_RegWriteM && (i_RA2E == i_WA3M))      fwd_b = FWD_MEM;
      else if (i_RegWriteW && (i_RA2E == i_WA3W)) fwd_b = FWD_WB;
    end
  end

  assign ldrstall = i_MemToRegE & ((i_RA1D == i_WA3E) | (i_RA2D == i_WA3E));
  assign pcpend   = i_PCSrcD | i_PCSrcE | i_PCSrcM;

  // A memory stall freezes every stage, so load-use and branch bubbles wait for it to clear.
  always_comb begin
    o_DMemReq   = i_MemAccessM;
    o_ForwardAE = fwd_a;
    o_ForwardBE = fwd_b;
    o_StallF    = ldrstall | pcpend;
    o_StallD    = ldrstall;
    o_StallE    = 1'b0;
    o_StallM    = 1'b0;
    o_FlushD    = pcpend | i_PCSrcW | i_BranchTakenE;
    o_FlushE    = ldrstall | i_BranchTakenE;
    o_FlushW    = 1'b0;
    if (memstall) begin
      o_StallF = 1'b1;
      o_StallD = 1'b1;
      o_StallE = 1'b1;
      o_StallM = 1'b1;
      o_FlushD = 1'b0;
      o_FlushE = 1'b0;
      o_FlushW = 1'b1;
    end
    if (i_RESET) begin
      o_DMemReq   = 1'b0;
      o_ForwardAE = FWD_RF;
      o_ForwardBE = FWD_RF;
      o_StallF    = 1'b0;
      o_StallD    = 1'b0;
      o_StallE    = 1'b0;
      o_StallM    = 1'b0;
      o_FlushD    = 1'b1;
      o_FlushE    = 1'b1;
      o_FlushW    = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((ldrstall || memstall) && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CntWidth'(1);
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) stall_cnt_q <= '0;
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign o_StallCycles = stall_cnt_q;

endmodule
